image_point_stream: RTL and testbench

Parametrised streaming pixel point-processor for the image-processing path. It takes RGB pixels from an upstream reader on a valid/ready stream, PPC pixels per beat. It applies one run-time-selected point operation (pass, brightness add/subtract with saturation, grayscale invert, threshold) through a 2-stage pipeline with full backpressure. It tags each output beat with frame position (SOF/EOL/EOF) for the downstream BMP writer.

---
 rtl/image_point_stream.sv | 205 ++++++++++++++++++++
 tb/tb_image_point_stream.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_point_stream.sv
// Streaming RGB point processor: PPC pixels per beat, two-stage pipeline
// with full valid/ready backpressure, per-frame shadowed configuration and
// SOF/EOL/EOF position tagging for the downstream writer.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high; valid never depends on ready, and data/tags hold
// while valid is high and ready is low.
module image_point_stream #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int PPC    = 2,
    parameter int DW     = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [2:0]            cfg_mode,
    input  logic [DW-1:0]         cfg_value,
    input  logic [DW-1:0]         cfg_threshold,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [3*DW*PPC-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*DW*PPC-1:0]   out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  frame_done,
    output logic                  sync_err
);

    localparam int PW = 3 * DW;
    localparam int BW = PW * PPC;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [DW-1:0] MAXV = '1;

    // Leaves reset low so in_ready stays 0 for as long as HRESET is high
    logic          run;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [2:0]    sh_mode;
    logic [DW-1:0] sh_value;
    logic [DW-1:0] sh_thr;

    logic              s1_valid;
    logic [BW-1:0]     s1_data;
    logic [DW*PPC-1:0] s1_gray;
    logic              s1_sof, s1_eol, s1_eof;
    logic [2:0]        s1_mode;
    logic [DW-1:0]     s1_value;
    logic [DW-1:0]     s1_thr;

    logic              s2_load, s1_load, accept;
    logic              at_origin, frame_start, beat_eol, beat_eof;
    logic [CW-1:0]     pos_col;
    logic [RW-1:0]     pos_row;
    logic [2:0]        eff_mode;
    logic [DW-1:0]     eff_value, eff_thr;
    logic [DW*PPC-1:0] gray_in;
    logic [DW+1:0]     gsum;
    logic [BW-1:0]     s2_next;
    logic [DW-1:0]     ch, gr, res;
    logic [DW:0]       add_sum;
    logic signed [DW:0] sub_diff;

    // Pipeline advance and the input-side position/config decode
    always_comb begin
        s2_load     = ~out_valid | out_ready;
        s1_load     = ~s1_valid | s2_load;
        in_ready    = run & s1_load;
        accept      = in_valid & in_ready;
        at_origin   = (col == '0) && (row == '0);
        pos_col     = in_sof ? '0 : col;
        pos_row     = in_sof ? '0 : row;
        frame_start = in_sof | at_origin;
        beat_eol    = (pos_col == CW'(WIDTH - PPC));
        beat_eof    = beat_eol && (pos_row == RW'(HEIGHT - 1));
        // The frame-start beat already uses the freshly sampled config
        eff_mode    = frame_start ? cfg_mode      : sh_mode;
        eff_value   = frame_start ? cfg_value     : sh_value;
        eff_thr     = frame_start ? cfg_threshold : sh_thr;
    end

    // Per-pixel gray = floor((R+G+B)/3), sum carried at DW+2 bits
    always_comb begin
        gray_in = '0;
        gsum    = '0;
        for (int p = 0; p < PPC; p++) begin
            gsum = {2'b00, in_data[PW*p+2*DW +: DW]}
                 + {2'b00, in_data[PW*p+DW +: DW]}
                 + {2'b00, in_data[PW*p +: DW]};
            gray_in[DW*p +: DW] = DW'(gsum / (DW+2)'(3));
        end
    end

    // Position counters, shadow config and the sync error pulse
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            run      <= 1'b0;
            col      <= '0;
            row      <= '0;
            sh_mode  <= 3'd0;
            sh_value <= '0;
            sh_thr   <= '0;
            sync_err <= 1'b0;
        end else begin
            run      <= 1'b1;
            // Flags SOF away from the origin, and an origin beat lacking SOF
            sync_err <= accept & (in_sof ^ at_origin);
            if (accept) begin
                if (frame_start) begin
                    sh_mode  <= cfg_mode;
                    sh_value <= cfg_value;
                    sh_thr   <= cfg_threshold;
                end
                if (beat_eol) begin
                    col <= '0;
                    row <= (pos_row == RW'(HEIGHT - 1)) ? '0 : pos_row + RW'(1);
                end else begin
                    col <= pos_col + CW'(PPC);
                    row <= pos_row;
                end
            end
        end
    end

    // Stage 1: register pixels, gray, tags and the config the beat will use
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_gray  <= '0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_mode  <= 3'd0;
            s1_value <= '0;
            s1_thr   <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data  <= in_data;
                s1_gray  <= gray_in;
                s1_sof   <= frame_start;
                s1_eol   <= beat_eol;
                s1_eof   <= beat_eof;
                s1_mode  <= eff_mode;
                s1_value <= eff_value;
                s1_thr   <= eff_thr;
            end
        end
    end

    // Stage 2 datapath: apply the beat's mode to every channel
    always_comb begin
        s2_next  = '0;
        ch       = '0;
        gr       = '0;
        res      = '0;
        add_sum  = '0;
        sub_diff = '0;
        for (int p = 0; p < PPC; p++) begin
            gr = s1_gray[DW*p +: DW];
            for (int c = 0; c < 3; c++) begin
                ch       = s1_data[PW*p+DW*c +: DW];
                add_sum  = {1'b0, ch} + {1'b0, s1_value};
                sub_diff = $signed({1'b0, ch}) - $signed({1'b0, s1_value});
                case (s1_mode)
                    3'd1:    res = add_sum[DW] ? MAXV : add_sum[DW-1:0];
                    3'd2:    res = (sub_diff < 0) ? '0 : sub_diff[DW-1:0];
                    3'd3:    res = MAXV - gr;
                    3'd4:    res = (gr > s1_thr) ? MAXV : '0;
                    default: res = ch;
                endcase
                s2_next[PW*p+DW*c +: DW] = res;
            end
        end
    end

    // Stage 2 / output register plus the frame-done pulse
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid & out_ready & out_eof;
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s2_next;
                    out_sof  <= s1_sof;
                    out_eol  <= s1_eol;
                    out_eof  <= s1_eof;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_point_stream.sv
// Bench for image_point_stream on a 4x2 image, two pixels per beat.
module tb_image_point_stream;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int P  = 2;
    localparam int DW = 8;
    localparam int BW = 3 * DW * P;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [2:0]    cfg_mode;
    logic [DW-1:0] cfg_value, cfg_threshold;
    logic          in_valid, in_ready, in_sof;
    logic [BW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [BW-1:0] out_data;
    logic          out_sof, out_eol, out_eof, frame_done, sync_err;

    image_point_stream #(.WIDTH(W), .HEIGHT(H), .PPC(P), .DW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cfg_mode(cfg_mode), .cfg_value(cfg_value), .cfg_threshold(cfg_threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    // Clock and reset-release tracking
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of one channel and of one beat
    function automatic logic [DW-1:0] ch_op(input int c, input int gray, input int mode,
                                            input int val, input int thr);
        int r;
        case (mode)
            1:       r = (c + val > 255) ? 255 : c + val;
            2:       r = (c - val < 0) ? 0 : c - val;
            3:       r = 255 - gray;
            4:       r = (gray > thr) ? 255 : 0;
            default: r = c;
        endcase
        return r[DW-1:0];
    endfunction

    function automatic logic [BW-1:0] model_beat(input logic [BW-1:0] d, input int mode,
                                                 input int val, input int thr);
        logic [BW-1:0] o;
        int r, g, b, gray;
        o = '0;
        for (int p = 0; p < P; p++) begin
            r = int'(d[24*p+16 +: 8]);
            g = int'(d[24*p+8 +: 8]);
            b = int'(d[24*p +: 8]);
            gray = (r + g + b) / 3;
            o[24*p+16 +: 8] = ch_op(r, gray, mode, val, thr);
            o[24*p+8 +: 8]  = ch_op(g, gray, mode, val, thr);
            o[24*p +: 8]    = ch_op(b, gray, mode, val, thr);
        end
        return o;
    endfunction

    // Scoreboard state
    logic [BW+2:0] exp_q[$];
    int            t_q[$];
    logic [BW-1:0] out_log[$];
    int  m_col, m_row, sh_mode, sh_val, sh_thr;
    bit  sync_pend, fd_pend, stall_prev, lat_mode, bp_on, tb_run;
    logic [BW+2:0] held;
    int  acc_cnt, del_cnt, cyc, fd_count, se_count;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) tb_run <= 1'b0;
        else        tb_run <= 1'b1;
    end

    always @(posedge HCLK) cyc <= cyc + 1;

    // Monitor: inputs change only just after posedge, so negedge values
    // predict the handshakes of the coming edge
    always @(negedge HCLK) begin : monitor
        int pc, pr, t;
        bit at0, exp_sync, eol, eof, sof;
        logic [BW+2:0] e;
        if (HRESET) begin
            exp_q.delete();
            t_q.delete();
            m_col = 0; m_row = 0; sh_mode = 0; sh_val = 0; sh_thr = 0;
            sync_pend = 0; fd_pend = 0; stall_prev = 0;
            acc_cnt = 0; del_cnt = 0;
        end else begin
            check_val("in_ready", in_ready, tb_run && ((acc_cnt - del_cnt) < 2 || out_ready));
            if (stall_prev) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data", {out_data, out_sof, out_eol, out_eof}, held);
            end
            stall_prev = out_valid && !out_ready;
            held = {out_data, out_sof, out_eol, out_eof};
            if (sync_err || sync_pend) check_val("sync_err", sync_err, sync_pend);
            if (frame_done || fd_pend) check_val("frame_done", frame_done, fd_pend);
            if (sync_err) se_count++;
            if (frame_done) fd_count++;
            sync_pend = 0;
            fd_pend = 0;
            if (out_valid && out_ready) begin
                del_cnt++;
                out_log.push_back(out_data);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    t = t_q.pop_front();
                    check_val("beat", {out_data, out_sof, out_eol, out_eof}, e);
                    fd_pend = e[0];
                    if (lat_mode) check_val("latency", cyc + 1 - t, 2);
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                at0 = (m_col == 0 && m_row == 0);
                if (in_sof) begin
                    exp_sync = !at0; pc = 0; pr = 0;
                end else begin
                    exp_sync = at0; pc = m_col; pr = m_row;
                end
                sof = (pc == 0 && pr == 0);
                if (sof) begin
                    sh_mode = int'(cfg_mode);
                    sh_val  = int'(cfg_value);
                    sh_thr  = int'(cfg_threshold);
                end
                eol = (pc == W - P);
                eof = eol && (pr == H - 1);
                exp_q.push_back({model_beat(in_data, sh_mode, sh_val, sh_thr), sof, eol, eof});
                t_q.push_back(cyc + 1);
                sync_pend = exp_sync;
                if (eol) begin
                    m_col = 0;
                    m_row = (pr == H - 1) ? 0 : pr + 1;
                end else begin
                    m_col = pc + P;
                    m_row = pr;
                end
            end
        end
    end

    // Pseudo-random downstream backpressure
    always @(posedge HCLK) begin
        if (bp_on) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input logic sof);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        n = 0;
        @(negedge HCLK);
        while (!in_ready && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 200) check_val("accept_timeout", 0, 1);
        @(posedge HCLK);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    function automatic logic [BW-1:0] rnd_beat();
        return {$urandom, $urandom};
    endfunction

    task automatic send_frame(input logic [BW-1:0] first, input int max_gap);
        send_beat(first, 1'b1);
        for (int i = 1; i < (W / P) * H; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_beat(rnd_beat(), 1'b0);
        end
    endtask

    task automatic set_cfg(input int mode, input int val, input int thr);
        cfg_mode      = mode[2:0];
        cfg_value     = val[DW-1:0];
        cfg_threshold = thr[DW-1:0];
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge HCLK);
            n++;
        end
        #1;
        if (n >= 500) check_val("drain_timeout", 0, 1);
        idle(2);
    endtask

    // Main sequence and final report
    initial begin : main
        int fd0, se0;
        logic [BW-1:0] d2;
        HRESET = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        out_ready = 1'b0; bp_on = 0; lat_mode = 0;
        cyc = 0; fd_count = 0; se_count = 0;
        set_cfg(0, 0, 0);
        repeat (3) @(negedge HCLK);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_tags", {out_sof, out_eol, out_eof}, 0);
        check_val("rst_pulses", {frame_done, sync_err}, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        check_val("ready_after_reset", in_ready, 1);

        // Pass-through frame, output ready throughout
        out_ready = 1'b1;
        lat_mode = 1;
        fd0 = fd_count;
        send_frame(rnd_beat(), 0);
        wait_drain();
        check_val("frame_done_count", fd_count - fd0, 1);

        // Brightness add / subtract with saturation
        out_log.delete();
        set_cfg(1, 100, 0);
        send_frame({24'h00FF64, 24'hC80A9B}, 0);
        wait_drain();
        check_val("add_px0", out_log[0][23:0], 24'hFF6EFF);
        check_val("add_px1", out_log[0][47:24], 24'h64FFC8);
        out_log.delete();
        set_cfg(2, 100, 0);
        send_frame({24'h00FF64, 24'hC80A9B}, 0);
        wait_drain();
        check_val("sub_px0", out_log[0][23:0], 24'h640037);
        check_val("sub_px1", out_log[0][47:24], 24'h009B00);

        // Invert and threshold boundary
        out_log.delete();
        set_cfg(3, 0, 0);
        send_frame({24'h000000, 24'h1E3C5B}, 0);
        wait_drain();
        check_val("invert_px0", out_log[0][23:0], 24'hC3C3C3);
        check_val("invert_px1", out_log[0][47:24], 24'h000000 | 24'hFFFFFF);
        out_log.delete();
        set_cfg(4, 0, 90);
        send_frame({24'h5C5A5B, 24'h5A5A5A}, 0);
        wait_drain();
        check_val("thr_eq", out_log[0][23:0], 24'h000000);
        check_val("thr_above", out_log[0][47:24], 24'hFFFFFF);

        // Random backpressure over three frames
        lat_mode = 0;
        bp_on = 1;
        for (int f = 0; f < 3; f++) begin
            set_cfg($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
            send_frame(rnd_beat(), (f == 1) ? 0 : 2);
        end
        wait_drain();
        bp_on = 0;
        idle(1);
        out_ready = 1'b1;
        idle(1);

        // Premature SOF and missing SOF
        lat_mode = 1;
        set_cfg(0, 0, 0);
        se0 = se_count;
        send_beat(rnd_beat(), 1'b1);
        send_beat(rnd_beat(), 1'b0);
        send_beat(rnd_beat(), 1'b1);
        for (int i = 0; i < 3; i++) send_beat(rnd_beat(), 1'b0);
        send_beat(rnd_beat(), 1'b0);
        for (int i = 0; i < 3; i++) send_beat(rnd_beat(), 1'b0);
        wait_drain();
        check_val("sync_err_count", se_count - se0, 2);

        // Mode change mid-frame waits for the next SOF
        out_log.delete();
        set_cfg(0, 0, 0);
        d2 = rnd_beat();
        send_beat(rnd_beat(), 1'b1);
        send_beat(rnd_beat(), 1'b0);
        set_cfg(3, 0, 0);
        send_beat(d2, 1'b0);
        send_beat(rnd_beat(), 1'b0);
        send_frame({24'h000000, 24'h1E3C5B}, 0);
        wait_drain();
        check_val("midframe_cfg_held", out_log[2], d2);
        check_val("next_frame_cfg", out_log[4][23:0], 24'hC3C3C3);

        // Reset in the middle of a stalled frame
        lat_mode = 0;
        out_ready = 1'b0;
        set_cfg(0, 0, 0);
        send_beat(rnd_beat(), 1'b1);
        send_beat(rnd_beat(), 1'b0);
        #2;
        HRESET = 1'b1;
        #1;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_in_ready", in_ready, 0);
        check_val("midrst_out_data", {out_data, out_sof}, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        out_ready = 1'b1;
        idle(1);
        lat_mode = 1;
        fd0 = fd_count;
        set_cfg(1, 37, 0);
        send_frame(rnd_beat(), 1);
        wait_drain();
        check_val("restart_frame_done", fd_count - fd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
